deriv_sequencer: RTL
====================

DERIV_SEQUENCER -- requirements
Module: deriv_sequencer

Interface
REQ-001 SHALL have parameter NWBITS, default 16, weight word width.
REQ-002 SHALL have parameter NHIDDEN, default 64, number of hidden neurons.
REQ-003 SHALL have parameter NOUT, default 10, number of output classes.
REQ-004 SHALL have ports: clk input 1, sole clock, rising edge; reset input 1, asynchronous active-high.
REQ-005 SHALL have ports: start input 1, request one backprop pass; pos_idx input 4, positive class index; neg_idx input 4, negative class index.
REQ-006 SHALL have ports: w_rd_en output 1, weight memory read strobe; w_addr output clog2(NOUT*NHIDDEN), read address; w_rdata input NWBITS signed, read data.
REQ-007 SHALL have ports: weight_pos output NWBITS signed and weight_neg output NWBITS signed, broadcast to all hidden-neuron derivative units.
REQ-008 SHALL have ports: enable_neuron output NHIDDEN, one-hot per-neuron enable; busy output 1; done output 1, one-cycle pulse; err output 1, index error flag.

Function
REQ-009 SHALL implement FSM states IDLE, RD_POS, RD_NEG, CAP, FIRE, DONE; neuron counter h, 0..NHIDDEN-1.
REQ-010 In IDLE, start=1 SHALL latch pos_idx/neg_idx, clear h and err, and go to RD_POS; start outside IDLE SHALL be ignored.
REQ-011 If either latched index >= NOUT, the FSM SHALL go directly to DONE with err=1 and SHALL issue no reads or enables.
REQ-012 RD_POS SHALL assert w_rd_en with w_addr = pos_idx*NHIDDEN + h.
REQ-013 RD_NEG SHALL assert w_rd_en with w_addr = neg_idx*NHIDDEN + h and register w_rdata into weight_pos.
REQ-014 Memory read latency is exactly one cycle: CAP SHALL register w_rdata into weight_neg with w_rd_en=0.
REQ-015 FIRE SHALL assert enable_neuron[h] for exactly one cycle, all other bits 0, with weight_pos/weight_neg stable.
REQ-016 From FIRE, the FSM SHALL go to RD_POS with h+1 if h<NHIDDEN-1, else to DONE.
REQ-017 DONE SHALL assert done for one cycle and return to IDLE; err SHALL hold until the next accepted start.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 Latency: done SHALL assert 4*NHIDDEN+1 cycles after the start-accept edge; an index error SHALL give done 1 cycle after accept.
REQ-020 weight_pos/weight_neg SHALL hold their last values outside capture states; w_addr SHALL be 0 when w_rd_en=0.

Reset
REQ-021 Reset SHALL force IDLE, h=0, and set busy, done, err, w_rd_en, enable_neuron, w_addr, weight_pos and weight_neg to 0, taking effect immediately.
REQ-022 Reset asserted mid-pass SHALL abort the pass with no done pulse; the first start after release SHALL run a full pass.

Configuration
REQ-023 Macro DERIV_SAME_IDX_SKIP_EN SHALL select same-index handling.
REQ-024 With DERIV_SAME_IDX_SKIP_EN defined and pos_idx==neg_idx, the FSM SHALL skip RD_POS/RD_NEG/CAP, force both weights to 0, and run FIRE back to back, one neuron per cycle; done SHALL follow NHIDDEN+1 cycles after accept.
REQ-025 Without the macro, equal indices SHALL run the normal 4-cycle-per-neuron sequence.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the NWBITS/NHIDDEN/NOUT defaults and the address-width function.
REQ-027 No sub-module SHALL be instantiated; the one-hot enable decode is inline logic.

Verification (NHIDDEN=4, NOUT=10, memory word = 16*class + h)
REQ-028 start with pos=3, neg=7 -> reads at addresses 12,28,13,29,14,30,15,31; FIRE h=0 shows weight_pos=48, weight_neg=112; done 17 cycles after accept.
REQ-029 start with pos=12 -> err=1, done 1 cycle after accept, w_rd_en and enable_neuron never asserted.
REQ-030 Second start held high during a pass -> ignored; exactly one done pulse; enable_neuron bits 0..3 fire once each, in order.
REQ-031 Reset at cycle 6 of a pass -> all outputs 0 at once, no done pulse; the next start completes normally.
REQ-032 pos=neg=5 with DERIV_SAME_IDX_SKIP_EN -> no reads, weights 0, enables on 4 consecutive cycles, done 5 cycles after accept; without the macro -> 17-cycle pass with equal weights.

Source files
------------

// File: rtl/deriv_sequencer_pkg.sv
// Shared definitions for deriv_sequencer: FSM state type, parameter defaults
// and the address-width helper.
package deriv_sequencer_pkg;

  localparam int DEF_NWBITS  = 16;
  localparam int DEF_NHIDDEN = 64;
  localparam int DEF_NOUT    = 10;

  typedef enum logic [2:0] {
    IDLE,
    RD_POS,
    RD_NEG,
    CAP,
    FIRE,
    DONE
  } state_t;

  // Width needed to address 'depth' entries; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/deriv_sequencer.sv
// Backprop derivative sequencer: fetches the positive/negative class weights for
// each hidden neuron and fires that neuron's derivative unit. Optional macro
// DERIV_SAME_IDX_SKIP_EN fast-paths passes whose two class indices are equal.
module deriv_sequencer
  import deriv_sequencer_pkg::*;
#(
  parameter int NWBITS  = DEF_NWBITS,
  parameter int NHIDDEN = DEF_NHIDDEN,
  parameter int NOUT    = DEF_NOUT
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [3:0]                               pos_idx,
  input  logic [3:0]                               neg_idx,
  output logic                                     w_rd_en,
  output logic [addr_width(NOUT*NHIDDEN)-1:0]      w_addr,
  input  logic signed [NWBITS-1:0]                 w_rdata,
  output logic signed [NWBITS-1:0]                 weight_pos,
  output logic signed [NWBITS-1:0]                 weight_neg,
  output logic [NHIDDEN-1:0]                       enable_neuron,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err
);

  localparam int AW = addr_width(NOUT * NHIDDEN);
  localparam int HW = addr_width(NHIDDEN);

  state_t          state;
  logic [HW-1:0]   h;
  logic [HW-1:0]   h_nxt;
  logic [3:0]      pos_q;
  logic [3:0]      neg_q;
  logic            skip_q;
  logic            idx_bad;
  logic            same_skip;
  logic            h_last;

  assign idx_bad = (int'(pos_idx) >= NOUT) || (int'(neg_idx) >= NOUT);
  assign h_last  = (int'(h) == NHIDDEN - 1);
  assign h_nxt   = h + HW'(1);

`ifdef DERIV_SAME_IDX_SKIP_EN
  assign same_skip = (pos_idx == neg_idx);
`else
  assign same_skip = 1'b0;
`endif

  function automatic logic [AW-1:0] addr_of(input logic [3:0] cls, input logic [HW-1:0] hh);
    return AW'(int'(cls) * NHIDDEN + int'(hh));
  endfunction

  // Outputs are registered alongside the state: each transition loads the
  // output values belonging to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      h             <= '0;
      pos_q         <= '0;
      neg_q         <= '0;
      skip_q        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      w_rd_en       <= 1'b0;
      w_addr        <= '0;
      enable_neuron <= '0;
      weight_pos    <= '0;
      weight_neg    <= '0;
    end else begin
      // NOTE: pulse outputs get a default here so every state only sets what it
      // asserts; with non-blocking assignment the later case-branch write wins.
      done          <= 1'b0;
      w_rd_en       <= 1'b0;
      w_addr        <= '0;
      enable_neuron <= '0;

      case (state)
        IDLE: begin
          if (start) begin
            pos_q  <= pos_idx;
            neg_q  <= neg_idx;
            skip_q <= same_skip;
            h      <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            if (idx_bad) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else if (same_skip) begin
              weight_pos    <= '0;
              weight_neg    <= '0;
              enable_neuron <= NHIDDEN'(1);
              state         <= FIRE;
            end else begin
              w_rd_en <= 1'b1;
              w_addr  <= addr_of(pos_idx, '0);
              state   <= RD_POS;
            end
          end
        end

        RD_POS: begin
          w_rd_en <= 1'b1;
          w_addr  <= addr_of(neg_q, h);
          state   <= RD_NEG;
        end

        // Read data arrives one cycle after its strobe.
        RD_NEG: begin
          weight_pos <= w_rdata;
          state      <= CAP;
        end

        CAP: begin
          weight_neg    <= w_rdata;
          enable_neuron <= NHIDDEN'(1) << h;
          state         <= FIRE;
        end

        FIRE: begin
          if (h_last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            h <= h_nxt;
            if (skip_q) begin
              enable_neuron <= NHIDDEN'(1) << h_nxt;
              state         <= FIRE;
            end else begin
              w_rd_en <= 1'b1;
              w_addr  <= addr_of(pos_q, h_nxt);
              state   <= RD_POS;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
